pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Parametrised program-counter generator for the IF stage; successor to the fixed 32-bit stall-only PC.
//   Adds: reset vector, start/halt FSM, a prioritised next-PC select (trap > redirect > stall > increment)
//   with alignment check, and an optional return-address stack (RAS).
//   Drives the I-memory address and the IF/ID valid bit.
// PARAMETERS
//   PC_W        32      PC width in bits; all PC arithmetic is modulo 2^PC_W
//   RESET_VEC   0       pc_o value after reset
//   TRAP_VEC    'h80    pc_o target on trap_i
//   INSTR_BYTES 4       sequential increment; power of two; ALIGN = log2(INSTR_BYTES)
//   RAS_DEPTH   4       RAS entries; power of two, >=2 (used only with PC_RAS_EN)
// PORTS
//   clk_i            in   1     clock, rising edge
//   rst_i            in   1     asynchronous, active-low reset
//   start_i          in   1     leave IDLE/HALT and begin fetching
//   halt_i           in   1     stop fetching (enter HALT)
//   pc_write_i       in   1     0 = stall (hold PC); 1 = PC may advance
//   redirect_valid_i in   1     taken branch/jump from EX
//   redirect_pc_i    in   PC_W  redirect target
//   trap_i           in   1     exception; jump to TRAP_VEC
//   call_i           in   1     current redirect is a call (push return address)
//   ret_i            in   1     instruction at pc_o is a return (pop predicted target)
//   pc_o             out  PC_W  current fetch PC (registered)
//   pc_plus_o        out  PC_W  pc_o + INSTR_BYTES (combinational, wraps)
//   valid_o          out  1     pc_o is a valid fetch this cycle (registered)
//   misalign_o       out  1     1-cycle pulse: last redirect target was misaligned
//   ras_empty_o      out  1     RAS holds no entries
// BEHAVIOUR
//   Reset (rst_i=0, async): pc_o=RESET_VEC, valid_o=0, misalign_o=0, state=IDLE, RAS emptied.
//   FSM states: IDLE, RUN, HALT.
//     IDLE: pc_o held; valid_o=0; start_i=1 -> RUN on next edge; pc_o still RESET_VEC, valid_o=1.
//     RUN: halt_i=1 -> HALT on next edge (valid_o=0, pc_o held); halt_i has priority over the next-PC update
//       in the same cycle, except trap_i, which still loads TRAP_VEC before entering HALT.
//     HALT: pc_o held; valid_o=0; start_i=1 -> RUN, resuming at the held pc_o.
//   Next-PC in RUN (registered, 1-cycle latency), priority high->low:
//     1 trap_i             -> TRAP_VEC (ignores pc_write_i)
//     2 redirect_valid_i   -> {redirect_pc_i[PC_W-1:ALIGN], ALIGN'b0} (ignores pc_write_i; flushes stall)
//                             misalign_o=1 next cycle if redirect_pc_i[ALIGN-1:0]!=0
//     3 pc_write_i=0       -> hold pc_o; valid_o stays 1
//     4 ret_i && RAS non-empty (PC_RAS_EN only) -> RAS top, pop
//     5 otherwise          -> pc_o + INSTR_BYTES; all-ones region wraps to 0, no flag
//   trap_i or redirect_valid_i in IDLE/HALT: ignored.
//   misalign_o is 0 in every cycle not flagged by rule 2.
//   Reset asserted mid-RUN returns to IDLE immediately, with no pending update.
// CONFIGURATION
//   PC_RAS_EN defined:
//     - Circular RAS of RAS_DEPTH x PC_W.
//     - Push pc_plus_o when call_i && redirect_valid_i && !trap_i in RUN.
//     - Pop per rule 4. Push while full overwrites the oldest entry; ras_empty_o stays 0.
//     - Pop on empty: ret_i ignored (rule 5).
//     - Push and pop in the same cycle: push only, since rule 2 wins.
//     - trap_i clears the RAS.
//   PC_RAS_EN undefined:
//     - No RAS storage; call_i/ret_i ignored; rule 4 absent; ras_empty_o tied 1.
// TESTING
//   1 Reset, start_i=1 one cycle -> pc_o: 0,0,4,8,... ; valid_o 0 then 1 from the cycle after start.
//   2 RUN at pc_o=0x10, pc_write_i=0 for 3 cycles -> pc_o=0x10 x3, then 0x14.
//     Repeat with redirect_valid_i=1, redirect_pc_i=0x40 during the stall -> pc_o=0x40 next cycle.
//   3 Same cycle: trap_i=1 and redirect to 0x40 -> pc_o=0x80. Redirect to 0x42 -> pc_o=0x40, misalign_o=1 one cycle.
//   4 PC_W=8, pc_o=0xFC -> next pc_o=0x00. halt_i at pc_o=0x20 -> pc_o holds 0x20, valid_o=0;
//     start_i -> resume at 0x20.
//   5 PC_RAS_EN: call at pc_o=0x10 redirecting to 0x100; ret_i at 0x108 -> pc_o=0x14, ras_empty_o=1.
//     5 calls with RAS_DEPTH=4 -> 4 rets return the newest 4; 5th ret -> sequential.
//   6 rst_i pulsed low mid-RUN, asynchronously -> pc_o=RESET_VEC and valid_o=0 before the next edge;
//     state IDLE until start_i.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with a start/halt FSM and a prioritised next-PC select.
// Define PC_RAS_EN to add a circular return-address stack; without it ras_empty_o is tied 1.
module pc_gen #(
   parameter int unsigned      PC_W        = 32,
   parameter logic [PC_W-1:0]  RESET_VEC   = '0,
   parameter logic [PC_W-1:0]  TRAP_VEC    = PC_W'('h80),
   parameter int unsigned      INSTR_BYTES = 4,
   parameter int unsigned      RAS_DEPTH   = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            halt_i,
   input  logic            pc_write_i,
   input  logic            redirect_valid_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   input  logic            trap_i,
   input  logic            call_i,
   input  logic            ret_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_plus_o,
   output logic            valid_o,
   output logic            misalign_o,
   output logic            ras_empty_o
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   // Masking with INSTR_BYTES-1 keeps the alignment logic valid even when INSTR_BYTES is 1.
   localparam logic [PC_W-1:0] AlignMask = PC_W'(INSTR_BYTES - 1);
   localparam logic [PC_W-1:0] Incr      = PC_W'(INSTR_BYTES);

   state_e          r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_valid;
   logic            r_misalign;

   logic [PC_W-1:0] w_pc_plus;
   logic [PC_W-1:0] w_redir_pc;
   logic            w_misalign;
   logic            w_running;
   logic            w_pop;
   logic [PC_W-1:0] w_ras_top;
   logic            w_ras_empty;

   assign w_pc_plus  = r_pc + Incr;
   assign w_redir_pc = redirect_pc_i & ~AlignMask;
   assign w_misalign = |(redirect_pc_i & AlignMask);
   assign w_running  = (r_state == StRun);

`ifdef PC_RAS_EN
   localparam int unsigned RasPtrW = $clog2(RAS_DEPTH);

   logic [PC_W-1:0]    r_ras_mem [RAS_DEPTH];
   logic [RasPtrW-1:0] r_ras_wr;
   logic [RasPtrW:0]   r_ras_cnt;
   logic [RasPtrW-1:0] w_ras_top_idx;
   logic               w_push;
   logic               w_clear;

   assign w_ras_top_idx = r_ras_wr - RasPtrW'(1);
   assign w_ras_top     = r_ras_mem[w_ras_top_idx];
   assign w_ras_empty   = (r_ras_cnt == '0);
   assign w_clear       = w_running && trap_i;
   assign w_push        = w_running && !halt_i && !trap_i && redirect_valid_i && call_i;
   assign w_pop         = w_running && !halt_i && !trap_i && !redirect_valid_i && pc_write_i &&
                          ret_i && !w_ras_empty;

   // The write pointer wraps freely, so a push while full overwrites the oldest entry.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ras_wr  <= '0;
         r_ras_cnt <= '0;
      end else if (w_clear) begin
         r_ras_wr  <= '0;
         r_ras_cnt <= '0;
      end else if (w_push) begin
         r_ras_wr <= r_ras_wr + RasPtrW'(1);
         if (r_ras_cnt != (RasPtrW + 1)'(RAS_DEPTH)) begin
            r_ras_cnt <= r_ras_cnt + (RasPtrW + 1)'(1);
         end
      end else if (w_pop) begin
         r_ras_wr  <= w_ras_top_idx;
         r_ras_cnt <= r_ras_cnt - (RasPtrW + 1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_ras_mem[r_ras_wr] <= w_pc_plus;
      end
   end
`else
   logic w_unused_ras;

   assign w_unused_ras = call_i ^ ret_i;
   assign w_ras_top    = '0;
   assign w_ras_empty  = 1'b1;
   assign w_pop        = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= StIdle;
         r_pc       <= RESET_VEC;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= 1'b0;
         unique case (r_state)
            StIdle, StHalt: begin
               if (start_i) begin
                  r_state <= StRun;
                  r_valid <= 1'b1;
               end
            end
            StRun: begin
               // Trap still lands on TRAP_VEC when halting; everything else yields to halt.
               if (trap_i) begin
                  r_pc <= TRAP_VEC;
               end else if (!halt_i) begin
                  if (redirect_valid_i) begin
                     r_pc       <= w_redir_pc;
                     r_misalign <= w_misalign;
                  end else if (!pc_write_i) begin
                     r_pc <= r_pc;
                  end else if (w_pop) begin
                     r_pc <= w_ras_top;
                  end else begin
                     r_pc <= w_pc_plus;
                  end
               end
               if (halt_i) begin
                  r_state <= StHalt;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= StIdle;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o        = r_pc;
   assign pc_plus_o   = w_pc_plus;
   assign valid_o     = r_valid;
   assign misalign_o  = r_misalign;
   assign ras_empty_o = w_ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a
// queue-based reference model; RAS scenarios run when PC_RAS_EN is defined.
module tb_pc_gen;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic        halt_i = 1'b0;
   logic        pc_write_i = 1'b1;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        trap_i = 1'b0;
   logic        call_i = 1'b0;
   logic        ret_i = 1'b0;
   logic [31:0] pc_o, pc_plus_o;
   logic        valid_o, misalign_o, ras_empty_o;
   logic [7:0]  pc8_o, pc8_plus_o;
   logic        valid8_o, mis8_o, empty8_o;

   int checks = 0;
   int errors = 0;

   // Reference model state: fetching flag, PC, misalign pulse and a capped return stack.
   bit          m_run;
   logic [31:0] m_pc;
   bit          m_mis;
   logic [31:0] m_ras[$];

   pc_gen u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
      .pc_write_i(pc_write_i), .redirect_valid_i(redirect_valid_i),
      .redirect_pc_i(redirect_pc_i), .trap_i(trap_i), .call_i(call_i), .ret_i(ret_i),
      .pc_o(pc_o), .pc_plus_o(pc_plus_o), .valid_o(valid_o), .misalign_o(misalign_o),
      .ras_empty_o(ras_empty_o)
   );

   pc_gen #(.PC_W(8)) u_dut8 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
      .pc_write_i(pc_write_i), .redirect_valid_i(redirect_valid_i),
      .redirect_pc_i(redirect_pc_i[7:0]), .trap_i(trap_i), .call_i(call_i), .ret_i(ret_i),
      .pc_o(pc8_o), .pc_plus_o(pc8_plus_o), .valid_o(valid8_o), .misalign_o(mis8_o),
      .ras_empty_o(empty8_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic bit m_empty();
      return m_ras.size() == 0;
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_pc  = 32'h0;
      m_mis = 0;
      m_ras.delete();
   endtask

   // One clock edge of the specified behaviour, evaluated from the inputs now applied.
   task automatic model_edge();
      bit mis = 0;
      if (!m_run) begin
         if (start_i) m_run = 1;
      end else begin
         if (trap_i) begin
            m_pc = 32'h80;
            m_ras.delete();
         end else if (!halt_i) begin
            if (redirect_valid_i) begin
`ifdef PC_RAS_EN
               if (call_i) begin
                  m_ras.push_back(m_pc + 32'd4);
                  if (m_ras.size() > 4) void'(m_ras.pop_front());
               end
`endif
               m_pc = redirect_pc_i & 32'hFFFF_FFFC;
               mis  = (redirect_pc_i % 4) != 0;
            end else if (!pc_write_i) begin
               m_pc = m_pc;
            end else if (ret_i && m_ras.size() > 0) begin
               m_pc = m_ras.pop_back();
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
         if (halt_i) m_run = 0;
      end
      m_mis = mis;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      start_i = 0; halt_i = 0; pc_write_i = 1; redirect_valid_i = 0;
      redirect_pc_i = '0; trap_i = 0; call_i = 0; ret_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 0;
      model_reset();
      #12;
      rst_i = 1;
      #8;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pc_o, valid_o, misalign_o, ras_empty_o} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset: pc=%h v=%b mis=%b empty=%b, want pc=0 v=0 mis=0 empty=1",
                  pc_o, valid_o, misalign_o, ras_empty_o);
      end
      checks++;
      if (pc_plus_o !== 32'h4) begin
         errors++;
         $display("FAIL reset_pc_plus: got %h want 00000004", pc_plus_o);
      end
      // Trap and redirect must be ignored while idle.
      trap_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h40;
      tick(); tick();
      clear_inputs();
      checks++;
      if ({pc_o, valid_o} !== {32'h0, 1'b0}) begin
         errors++;
         $display("FAIL idle_ignore: pc=%h v=%b, want pc=0 v=0", pc_o, valid_o);
      end
   endtask

   task automatic test_start_seq();
      start_i = 1;
      tick();
      start_i = 0;
      for (int i = 0; i <= 4; i++) begin
         if (i > 0) tick();
         checks++;
         if ({pc_o, valid_o} !== {32'(4 * i), 1'b1}) begin
            errors++;
            $display("FAIL start_seq[%0d]: pc=%h v=%b, want pc=%h v=1", i, pc_o, valid_o, 4 * i);
         end
      end
   endtask

   task automatic test_stall();
      pc_write_i = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({pc_o, valid_o} !== {32'h10, 1'b1}) begin
            errors++;
            $display("FAIL stall[%0d]: pc=%h v=%b, want pc=00000010 v=1", i, pc_o, valid_o);
         end
      end
      pc_write_i = 1;
      tick();
      checks++;
      if (pc_o !== 32'h14) begin
         errors++;
         $display("FAIL stall_release: pc=%h want 00000014", pc_o);
      end
      pc_write_i = 0;
      tick();
      redirect_valid_i = 1; redirect_pc_i = 32'h40;
      tick();
      clear_inputs();
      checks++;
      if ({pc_o, valid_o, misalign_o} !== {32'h40, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL stall_redirect: pc=%h v=%b mis=%b, want pc=00000040 v=1 mis=0",
                  pc_o, valid_o, misalign_o);
      end
   endtask

   task automatic test_trap_redirect();
      trap_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h40;
      tick();
      clear_inputs();
      checks++;
      if ({pc_o, misalign_o} !== {32'h80, 1'b0}) begin
         errors++;
         $display("FAIL trap_prio: pc=%h mis=%b, want pc=00000080 mis=0", pc_o, misalign_o);
      end
      redirect_valid_i = 1; redirect_pc_i = 32'h42;
      tick();
      clear_inputs();
      checks++;
      if ({pc_o, misalign_o} !== {32'h40, 1'b1}) begin
         errors++;
         $display("FAIL misalign: pc=%h mis=%b, want pc=00000040 mis=1", pc_o, misalign_o);
      end
      tick();
      checks++;
      if ({pc_o, misalign_o} !== {32'h44, 1'b0}) begin
         errors++;
         $display("FAIL misalign_pulse: pc=%h mis=%b, want pc=00000044 mis=0", pc_o, misalign_o);
      end
   endtask

   task automatic test_halt();
      redirect_valid_i = 1; redirect_pc_i = 32'h20;
      tick();
      clear_inputs();
      halt_i = 1;
      tick();
      halt_i = 0;
      trap_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h300;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({pc_o, valid_o} !== {32'h20, 1'b0}) begin
            errors++;
            $display("FAIL halt_hold[%0d]: pc=%h v=%b, want pc=00000020 v=0", i, pc_o, valid_o);
         end
         tick();
      end
      clear_inputs();
      start_i = 1;
      tick();
      start_i = 0;
      checks++;
      if ({pc_o, valid_o} !== {32'h20, 1'b1}) begin
         errors++;
         $display("FAIL halt_resume: pc=%h v=%b, want pc=00000020 v=1", pc_o, valid_o);
      end
      tick();
      halt_i = 1; trap_i = 1;
      tick();
      clear_inputs();
      checks++;
      if ({pc_o, valid_o} !== {32'h80, 1'b0}) begin
         errors++;
         $display("FAIL halt_trap: pc=%h v=%b, want pc=00000080 v=0", pc_o, valid_o);
      end
      start_i = 1;
      tick();
      start_i = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      start_i = 1;
      tick();
      clear_inputs();
      redirect_valid_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      clear_inputs();
      checks++;
      if ({pc8_o, pc8_plus_o, pc_o, pc_plus_o} !== {8'hFC, 8'h00, 32'hFFFF_FFFC, 32'h0}) begin
         errors++;
         $display("FAIL wrap_top: pc8=%h plus8=%h pc=%h plus=%h, want FC 00 FFFFFFFC 00000000",
                  pc8_o, pc8_plus_o, pc_o, pc_plus_o);
      end
      tick();
      checks++;
      if ({pc8_o, valid8_o, mis8_o, pc_o, misalign_o} !== {8'h00, 1'b1, 1'b0, 32'h0, 1'b0}) begin
         errors++;
         $display("FAIL wrap: pc8=%h v8=%b mis8=%b pc=%h mis=%b, want 00 1 0 00000000 0",
                  pc8_o, valid8_o, mis8_o, pc_o, misalign_o);
      end
   endtask

`ifdef PC_RAS_EN
   task automatic test_ras();
      logic [31:0] ret_addr[5];
      do_reset();
      start_i = 1;
      tick();
      clear_inputs();
      for (int i = 0; i < 4; i++) tick();
      redirect_valid_i = 1; call_i = 1; redirect_pc_i = 32'h100;
      tick();
      clear_inputs();
      checks++;
      if ({pc_o, ras_empty_o} !== {32'h100, 1'b0}) begin
         errors++;
         $display("FAIL ras_call: pc=%h empty=%b, want 00000100 0", pc_o, ras_empty_o);
      end
      tick(); tick();
      ret_i = 1;
      tick();
      ret_i = 0;
      checks++;
      if ({pc_o, ras_empty_o} !== {32'h14, 1'b1}) begin
         errors++;
         $display("FAIL ras_ret: pc=%h empty=%b, want 00000014 1", pc_o, ras_empty_o);
      end
      for (int k = 0; k < 5; k++) begin
         ret_addr[k] = m_pc + 32'd4;
         redirect_valid_i = 1; call_i = 1; redirect_pc_i = 32'(32'h1000 * (k + 1));
         tick();
         clear_inputs();
         tick();
      end
      for (int j = 0; j < 5; j++) begin
         logic [31:0] want;
         want = (j < 4) ? ret_addr[4 - j] : pc_o + 32'd4;
         ret_i = 1;
         tick();
         ret_i = 0;
         checks++;
         if (pc_o !== want) begin
            errors++;
            $display("FAIL ras_ret_%0d: pc=%h want %h", j, pc_o, want);
         end
      end
      redirect_valid_i = 1; call_i = 1; redirect_pc_i = 32'h500;
      tick();
      clear_inputs();
      trap_i = 1;
      tick();
      trap_i = 0;
      checks++;
      if ({pc_o, ras_empty_o} !== {32'h80, 1'b1}) begin
         errors++;
         $display("FAIL ras_trap_clear: pc=%h empty=%b, want 00000080 1", pc_o, ras_empty_o);
      end
   endtask
`else
   task automatic test_ras_absent();
      redirect_valid_i = 1; call_i = 1; redirect_pc_i = 32'h100;
      tick();
      clear_inputs();
      ret_i = 1;
      tick();
      ret_i = 0;
      checks++;
      if ({pc_o, ras_empty_o} !== {32'h104, 1'b1}) begin
         errors++;
         $display("FAIL ras_absent: pc=%h empty=%b, want 00000104 1", pc_o, ras_empty_o);
      end
   endtask
`endif

   task automatic test_async_reset();
      #2;
      rst_i = 0;
      #1;
      checks++;
      if ({pc_o, valid_o, misalign_o} !== {32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: pc=%h v=%b mis=%b, want 00000000 0 0",
                  pc_o, valid_o, misalign_o);
      end
      model_reset();
      #2;
      rst_i = 1;
      #5;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if ({pc_o, valid_o} !== {32'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle: pc=%h v=%b, want 00000000 0", pc_o, valid_o);
      end
      start_i = 1;
      tick();
      start_i = 0;
      tick();
      checks++;
      if ({pc_o, valid_o} !== {32'h4, 1'b1}) begin
         errors++;
         $display("FAIL reset_restart: pc=%h v=%b, want 00000004 1", pc_o, valid_o);
      end
   endtask

   task automatic test_random();
      do_reset();
      start_i = 1;
      tick();
      for (int n = 0; n < 600; n++) begin
         start_i          = ($urandom_range(0, 99) < 30);
         halt_i           = ($urandom_range(0, 99) < 3);
         trap_i           = ($urandom_range(0, 99) < 3);
         redirect_valid_i = ($urandom_range(0, 99) < 15);
         redirect_pc_i    = $urandom;
         call_i           = ($urandom_range(0, 99) < 50);
         ret_i            = ($urandom_range(0, 99) < 25);
         pc_write_i       = ($urandom_range(0, 99) < 80);
         tick();
         checks++;
         if ({pc_o, pc_plus_o, valid_o, misalign_o, ras_empty_o} !==
             {m_pc, m_pc + 32'd4, m_run, m_mis, m_empty()}) begin
            errors++;
            $display("FAIL random[%0d]: pc=%h plus=%h v=%b mis=%b e=%b, want %h %h %b %b %b",
                     n, pc_o, pc_plus_o, valid_o, misalign_o, ras_empty_o,
                     m_pc, m_pc + 32'd4, m_run, m_mis, m_empty());
         end
      end
      clear_inputs();
   endtask

   initial begin
      #6;
      test_reset();
      test_start_seq();
      test_stall();
      test_trap_redirect();
      test_halt();
      test_async_reset();
      test_wrap();
`ifdef PC_RAS_EN
      test_ras();
`else
      test_ras_absent();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
